// File: rtl/videoprocessor_s00_axi_regs.sv
// AXI4-Lite slave with four live configuration registers and frame-synchronous
// shadow copies that the video pipeline consumes at each frame boundary.
module videoprocessor_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  // write address / data / response
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  // read address / data
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  // video side
  input  logic                            frame_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
  output logic                            cfg_pending
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_live [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] r_cfg  [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                          r_awready;
  logic                          r_wready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic                          r_cfg_pending;

  logic       w_wr_fire;
  logic       w_rd_fire;
  logic [1:0] w_wr_idx;
  logic [1:0] w_rd_idx;
  logic       w_unused;

  // Address and data are held stable by the master while ready is high, so
  // the handshake cycle samples them directly without extra capture flops.
  assign w_wr_fire = r_awready & s00_axi_awvalid & r_wready & s00_axi_wvalid;
  assign w_rd_fire = r_arready & s00_axi_arvalid;
  assign w_wr_idx  = s00_axi_awaddr[3:2];
  assign w_rd_idx  = s00_axi_araddr[3:2];
  assign w_unused  = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  // Write address/data acceptance and response.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample pre-edge
      // values, which is what lets awready self-clear after exactly one cycle.
      r_awready <= s00_axi_awvalid & s00_axi_wvalid & ~r_awready & ~r_bvalid;
      r_wready  <= s00_axi_awvalid & s00_axi_wvalid & ~r_awready & ~r_bvalid;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
      end else if (s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Live registers with byte-lane enables.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      // NOTE: this is a 4-entry flop bank, not a RAM, so resetting every entry
      // is cheap and gives the pipeline a known configuration after reset.
      for (int i = 0; i < 4; i++) begin
        r_live[i] <= '0;
      end
    end else if (w_wr_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s00_axi_wstrb[b]) begin
          r_live[w_wr_idx][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read address acceptance and data return.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s00_axi_arvalid & ~r_arready & ~r_rvalid;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_live[w_rd_idx];
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Frame-synchronous shadows; a write landing on a frame edge stays pending
  // because the shadows copy the pre-write live values.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < 4; i++) begin
        r_cfg[i] <= '0;
      end
      r_cfg_pending <= 1'b0;
    end else begin
      if (frame_start) begin
        for (int i = 0; i < 4; i++) begin
          r_cfg[i] <= r_live[i];
        end
      end
      if (w_wr_fire) begin
        r_cfg_pending <= 1'b1;
      end else if (frame_start) begin
        r_cfg_pending <= 1'b0;
      end
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign cfg_reg0        = r_cfg[0];
  assign cfg_reg1        = r_cfg[1];
  assign cfg_reg2        = r_cfg[2];
  assign cfg_reg3        = r_cfg[3];
  assign cfg_pending     = r_cfg_pending;

endmodule

// File: tb/tb_videoprocessor_s00_axi_regs.sv
// Directed bench for videoprocessor_s00_axi_regs: table-driven register traffic
// followed by hand-written handshake, frame-sync and reset corner sequences.
module tb_videoprocessor_s00_axi_regs;

  logic        aclk;
  logic        areset;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        frame_start;
  logic [31:0] cfg_reg0;
  logic [31:0] cfg_reg1;
  logic [31:0] cfg_reg2;
  logic [31:0] cfg_reg3;
  logic        cfg_pending;

  int          checks;
  int          failures;
  logic [31:0] rd;
  int          bad;

  typedef struct {
    logic        is_read;
    logic [3:0]  addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
  } vec_t;

  vec_t vecs [15];

  videoprocessor_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .s00_axi_aclk   (aclk),
    .s00_axi_areset (areset),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .frame_start    (frame_start),
    .cfg_reg0       (cfg_reg0),
    .cfg_reg1       (cfg_reg1),
    .cfg_reg2       (cfg_reg2),
    .cfg_reg3       (cfg_reg3),
    .cfg_pending    (cfg_pending)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_awready();
    int n = 0;
    while (awready !== 1'b1 && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    check("awready_seen", awready, 1);
  endtask

  task automatic wait_arready();
    int n = 0;
    while (arready !== 1'b1 && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    check("arready_seen", arready, 1);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wait_awready();
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_bvalid", bvalid, 1);
    check("wr_bresp", bresp, 0);
    @(posedge aclk); #1;
    bready = 1'b0;
    check("wr_bvalid_clear", bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    wait_arready();
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rd_rvalid", rvalid, 1);
    check("rd_rresp", rresp, 0);
    d = rdata;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rd_rvalid_clear", rvalid, 0);
  endtask

  task automatic pulse_frame();
    @(negedge aclk);
    frame_start = 1'b1;
    @(negedge aclk);
    frame_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rresp"}, rresp, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_cfg0"}, cfg_reg0, 0);
    check({tag, "_cfg1"}, cfg_reg1, 0);
    check({tag, "_cfg2"}, cfg_reg2, 0);
    check({tag, "_cfg3"}, cfg_reg3, 0);
    check({tag, "_pending"}, cfg_pending, 0);
  endtask

  initial begin
    checks = 0; failures = 0;
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    frame_start = 1'b0;

    vecs[0]  = '{1'b0, 4'h0, 32'h0000_0001, 4'hF};
    vecs[1]  = '{1'b0, 4'h4, 32'h0000_0002, 4'hF};
    vecs[2]  = '{1'b0, 4'h8, 32'h0000_0003, 4'hF};
    vecs[3]  = '{1'b0, 4'hC, 32'h0000_0004, 4'hF};
    vecs[4]  = '{1'b1, 4'h0, 32'h0000_0001, 4'h0};
    vecs[5]  = '{1'b1, 4'h4, 32'h0000_0002, 4'h0};
    vecs[6]  = '{1'b1, 4'h8, 32'h0000_0003, 4'h0};
    vecs[7]  = '{1'b1, 4'hC, 32'h0000_0004, 4'h0};
    vecs[8]  = '{1'b0, 4'h0, 32'hFFFF_FFFF, 4'hF};
    vecs[9]  = '{1'b0, 4'h0, 32'h0000_00AA, 4'b0001};
    vecs[10] = '{1'b1, 4'h0, 32'hFFFF_FFAA, 4'h0};
    vecs[11] = '{1'b0, 4'h1, 32'h0000_BB00, 4'b0010};
    vecs[12] = '{1'b1, 4'h2, 32'hFFFF_BBAA, 4'h0};
    vecs[13] = '{1'b0, 4'hE, 32'h1234_5678, 4'b1100};
    vecs[14] = '{1'b1, 4'hC, 32'h1234_0004, 4'h0};

    repeat (3) @(negedge aclk);
    check_all_zero("reset");
    areset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_read) begin
        axi_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end
    end
    check("no_frame_cfg0", cfg_reg0, 0);
    check("no_frame_cfg3", cfg_reg3, 0);
    check("table_pending", cfg_pending, 1);

    // One-sided address or data must not be accepted.
    @(negedge aclk);
    awaddr = 4'h4; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
    bad = 0;
    repeat (3) begin @(posedge aclk); #1; if (awready || wready) bad++; end
    awvalid = 1'b0; wvalid = 1'b1;
    repeat (3) begin @(posedge aclk); #1; if (awready || wready) bad++; end
    check("one_sided_not_accepted", bad, 0);
    awvalid = 1'b1;
    wait_awready();
    check("wready_with_awready", wready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("cfg1_before_frame", cfg_reg1, 0);
    check("pending_after_write", cfg_pending, 1);
    pulse_frame();
    check("cfg1_after_frame", cfg_reg1, 32'h5);
    check("cfg0_after_frame", cfg_reg0, 32'hFFFF_BBAA);
    check("cfg3_after_frame", cfg_reg3, 32'h1234_0004);
    check("pending_cleared", cfg_pending, 0);

    // Write update edge coinciding with frame_start.
    @(negedge aclk);
    awaddr = 4'h8; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wait_awready();
    frame_start = 1'b1;
    @(posedge aclk); #1;
    frame_start = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("coinc_cfg2_old", cfg_reg2, 32'h3);
    check("coinc_pending", cfg_pending, 1);
    @(posedge aclk); #1;
    bready = 1'b0;
    pulse_frame();
    check("coinc_cfg2_new", cfg_reg2, 32'h9);
    check("coinc_pending_clear", cfg_pending, 0);

    // Read and write to the same register on the same edge.
    @(negedge aclk);
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b1;
    awaddr = 4'h8; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wait_awready();
    check("same_edge_arready", arready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_rvalid", rvalid, 1);
    check("same_edge_rdata_old", rdata, 32'h9);
    check("same_edge_bvalid", bvalid, 1);
    @(posedge aclk); #1;
    rready = 1'b0; bready = 1'b0;
    axi_read(4'h8, rd);
    check("same_edge_rdata_new", rd, 32'h77);

    // Write response back-pressure with a second write waiting.
    @(negedge aclk);
    awaddr = 4'h4; wdata = 32'hA5A5_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    wait_awready();
    @(posedge aclk); #1;
    wdata = 32'h0000_0002;
    check("bhold_bvalid", bvalid, 1);
    bad = 0;
    repeat (10) begin @(posedge aclk); #1; if (!bvalid || awready) bad++; end
    check("bhold_stall", bad, 0);
    bready = 1'b1;
    wait_awready();
    check("bhold_released", bvalid, 0);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bhold_second_bvalid", bvalid, 1);
    @(posedge aclk); #1;
    bready = 1'b0;
    axi_read(4'h4, rd);
    check("bhold_rdata", rd, 32'h2);

    // Read data back-pressure with a second read waiting.
    @(negedge aclk);
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    wait_arready();
    @(posedge aclk); #1;
    araddr = 4'h8;
    check("rhold_rvalid", rvalid, 1);
    check("rhold_rdata", rdata, 32'h2);
    bad = 0;
    repeat (10) begin @(posedge aclk); #1; if (!rvalid || arready || rdata !== 32'h2) bad++; end
    check("rhold_stable", bad, 0);
    rready = 1'b1;
    wait_arready();
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rhold_second_rvalid", rvalid, 1);
    check("rhold_second_rdata", rdata, 32'h77);
    @(posedge aclk); #1;
    rready = 1'b0;

    // Reset between write acceptance and response.
    @(negedge aclk);
    awaddr = 4'hC; wdata = 32'hDEAD_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wait_awready();
    #2 areset = 1'b1;
    #1 check_all_zero("mid_reset");
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    check("post_reset_no_bvalid", bvalid, 0);
    axi_read(4'hC, rd);
    check("post_reset_reg3", rd, 32'h0);
    axi_write(4'hC, 32'hCAFE_F00D, 4'hF);
    axi_read(4'hC, rd);
    check("post_reset_rw", rd, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
